// File: rtl/mcse_gpio_pkg.sv
`default_nettype none
// ============================================================================
// mcse_gpio_pkg : register offsets and packet field positions for the GPIO
//                 packet responder.
// Revision      : 1.0
// ============================================================================
package mcse_gpio_pkg;

  localparam int WRITE_BIT = 0;
  localparam int DMODE_LSB = 1;
  localparam int CTRL_LSB  = 3;
  localparam int ADDR_LSB  = 8;

  localparam logic [1:0] DMODE_32 = 2'b10;

  localparam logic [7:0] OFF_DIR     = 8'h00;
  localparam logic [7:0] OFF_OUT     = 8'h04;
  localparam logic [7:0] OFF_OUTAND  = 8'h08;
  localparam logic [7:0] OFF_OUTORR  = 8'h0C;
  localparam logic [7:0] OFF_OUTXOR  = 8'h10;
  localparam logic [7:0] OFF_IMASK   = 8'h14;
  localparam logic [7:0] OFF_IN      = 8'h18;
  localparam logic [7:0] OFF_ILAT    = 8'h1C;
  localparam logic [7:0] OFF_ILATCLR = 8'h20;

  function automatic int data_lsb(input int aw);
    return aw + ADDR_LSB;
  endfunction

  function automatic int src_lsb(input int aw);
    return 2 * aw + ADDR_LSB;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcse_gpio_sync.sv
`default_nettype none
// ============================================================================
// mcse_gpio_sync : N-bit two-flop synchronizer for asynchronous pad inputs.
// Revision       : 1.0
// ============================================================================
module mcse_gpio_sync #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_sync
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/mcse_gpio_responder.sv
`default_nettype none
// ============================================================================
// mcse_gpio_responder : packet-driven GPIO register file with synchronized
//                       inputs and rising-edge interrupt latch.
// Revision            : 1.0
// ============================================================================
module mcse_gpio_responder
  import mcse_gpio_pkg::*;
#(
  parameter int             N    = 32,
  parameter int             AW   = 32,
  parameter int             PW   = 2*AW+40,
  parameter logic [AW-9:0]  BASE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reg_access,
  input  logic [PW-1:0] reg_packet,
  output logic [N-1:0]  reg_rdata,
  output logic          reg_rvalid,
  output logic          reg_err,
  input  logic [N-1:0]  gpio_in,
  output logic [N-1:0]  gpio_out,
  output logic [N-1:0]  gpio_en,
  output logic [N-1:0]  gpio_ilat,
  output logic          gpio_irq
);

  localparam int DATA_LSB = data_lsb(AW);
  localparam int SRC_LSB  = src_lsb(AW);

  logic          w_write;
  logic [1:0]    w_dmode;
  logic [AW-1:0] w_dstaddr;
  logic [AW-1:0] w_data_full;
  logic [N-1:0]  w_wdata;
  logic [7:0]    w_offset;
  logic          w_mapped;
  logic          w_read_only;
  logic [N-1:0]  w_rd_val;
  logic          w_hit;
  logic          w_wr;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_sync;
  logic [N-1:0]  w_rise;
  logic          w_unused;

  logic [N-1:0]  dir_q,   dir_d;
  logic [N-1:0]  out_q,   out_d;
  logic [N-1:0]  imask_q, imask_d;
  logic [N-1:0]  ilat_q,  ilat_d;
  logic [N-1:0]  hist_q,  hist_d;
  logic [N-1:0]  rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q,    err_d;

  mcse_gpio_sync #(.N(N)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (gpio_in),
    .o_sync  (w_sync)
  );

  assign w_write     = reg_packet[WRITE_BIT];
  assign w_dmode     = reg_packet[DMODE_LSB +: 2];
  assign w_dstaddr   = reg_packet[ADDR_LSB +: AW];
  assign w_data_full = reg_packet[DATA_LSB +: AW];
  assign w_wdata     = w_data_full[N-1:0];
  assign w_offset    = w_dstaddr[7:0];
  assign w_unused    = ^{reg_packet[ADDR_LSB-1:CTRL_LSB], reg_packet[PW-1:SRC_LSB], w_data_full};

  always_comb begin
    w_mapped    = 1'b1;
    w_read_only = 1'b0;
    w_rd_val    = '0;
    unique case (w_offset)
      OFF_DIR:     w_rd_val = dir_q;
      OFF_OUT:     w_rd_val = out_q;
      OFF_OUTAND,
      OFF_OUTORR,
      OFF_OUTXOR,
      OFF_ILATCLR: w_rd_val = '0;
      OFF_IMASK:   w_rd_val = imask_q;
      OFF_IN: begin
        w_rd_val    = w_sync;
        w_read_only = 1'b1;
      end
      OFF_ILAT: begin
        w_rd_val    = ilat_q;
        w_read_only = 1'b1;
      end
      default:     w_mapped = 1'b0;
    endcase
  end

  assign w_hit  = (w_dmode == DMODE_32) && (w_dstaddr[AW-1:8] == BASE) &&
                  w_mapped && !(w_write && w_read_only);
  assign w_wr   = reg_access && w_hit && w_write;
  assign w_rise = w_sync & ~hist_q;

  always_comb begin
    dir_d   = dir_q;
    out_d   = out_q;
    imask_d = imask_q;
    w_clr   = '0;
    if (w_wr) begin
      case (w_offset)
        OFF_DIR:     dir_d   = w_wdata;
        OFF_OUT:     out_d   = w_wdata;
        OFF_OUTAND:  out_d   = out_q & w_wdata;
        OFF_OUTORR:  out_d   = out_q | w_wdata;
        OFF_OUTXOR:  out_d   = out_q ^ w_wdata;
        OFF_IMASK:   imask_d = w_wdata;
        OFF_ILATCLR: w_clr   = w_wdata;
        default:     ;
      endcase
    end
    // A fresh rise is OR-ed in after the clear so it survives a same-cycle clear.
    ilat_d = (ilat_q & ~w_clr) | w_rise;
    hist_d = w_sync;
  end

  always_comb begin
    rvalid_d = reg_access && !w_write;
    err_d    = reg_access && !w_hit;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rdata_d = w_hit ? w_rd_val : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q   <= '0;
      out_q   <= '0;
      imask_q <= '0;
      ilat_q  <= '0;
      hist_q  <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      imask_q <= imask_d;
      ilat_q  <= ilat_d;
      hist_q  <= hist_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign reg_err    = err_q;
  assign gpio_out   = out_q;
  assign gpio_en    = dir_q;
  assign gpio_ilat  = ilat_q;
  assign gpio_irq   = |(ilat_q & imask_q);

endmodule
`default_nettype wire

// File: tb/tb_mcse_gpio_responder.sv
`default_nettype none
// ============================================================================
// tb_mcse_gpio_responder : directed self-checking bench for the GPIO responder.
// Revision               : 1.0
// ============================================================================
module tb_mcse_gpio_responder;

  localparam int N  = 32;
  localparam int AW = 32;
  localparam int PW = 2*AW+40;

  logic          clk;
  logic          rst;
  logic          reg_access;
  logic [PW-1:0] reg_packet;
  logic [N-1:0]  reg_rdata;
  logic          reg_rvalid;
  logic          reg_err;
  logic [N-1:0]  gpio_in;
  logic [N-1:0]  gpio_out;
  logic [N-1:0]  gpio_en;
  logic [N-1:0]  gpio_ilat;
  logic          gpio_irq;

  int checks   = 0;
  int failures = 0;

  mcse_gpio_responder #(.N(N), .AW(AW), .PW(PW), .BASE(24'h000000)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_access (reg_access),
    .reg_packet (reg_packet),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .reg_err    (reg_err),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_en    (gpio_en),
    .gpio_ilat  (gpio_ilat),
    .gpio_irq   (gpio_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] dm, input logic [31:0] addr,
                       input logic [31:0] data);
    logic [PW-1:0] p;
    p = '0;
    p[0]                = w;
    p[2:1]              = dm;
    p[7:3]              = 5'h15;
    p[AW+7:8]           = addr;
    p[2*AW+7:AW+8]      = data;
    p[PW-1:2*AW+8]      = 32'hDEADBEEF;
    reg_access = 1'b1;
    reg_packet = p;
  endtask

  task automatic idle();
    reg_access = 1'b0;
    reg_packet = '0;
  endtask

  task automatic test_reset();
    // Load some state, then reset asynchronously mid-cycle with an access pending.
    drive(1'b1, 2'b10, 32'h04, 32'h12345678); tick();
    drive(1'b1, 2'b10, 32'h00, 32'h0000FFFF); tick();
    drive(1'b0, 2'b10, 32'h04, 32'h0);        tick();
    idle();
    checks++;
    if (reg_rdata !== 32'h12345678 || reg_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_read: rdata=%h rvalid=%b expected rdata=12345678 rvalid=1", reg_rdata, reg_rvalid);
    end
    drive(1'b1, 2'b10, 32'h04, 32'hFFFFFFFF);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gpio_out !== 32'h0 || gpio_en !== 32'h0 || gpio_ilat !== 32'h0 || gpio_irq !== 1'b0 ||
        reg_rdata !== 32'h0 || reg_rvalid !== 1'b0 || reg_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: out=%h en=%h ilat=%h irq=%b rdata=%h rvalid=%b err=%b expected all zero",
               gpio_out, gpio_en, gpio_ilat, gpio_irq, reg_rdata, reg_rvalid, reg_err);
    end
    tick();
    idle();
    checks++;
    if (gpio_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_drop_pending: out=%h expected 00000000", gpio_out);
    end
    rst = 1'b0;
    tick();
    drive(1'b1, 2'b10, 32'h00, 32'hFFFF0000); tick();
    idle();
    checks++;
    if (gpio_en !== 32'hFFFF0000 || reg_rvalid !== 1'b0 || reg_err !== 1'b0) begin
      failures++;
      $display("FAIL dir_write: en=%h rvalid=%b err=%b expected en=ffff0000 rvalid=0 err=0", gpio_en, reg_rvalid, reg_err);
    end
    drive(1'b0, 2'b10, 32'h00, 32'h0); tick();
    idle();
    checks++;
    if (reg_rvalid !== 1'b1 || reg_rdata !== 32'hFFFF0000) begin
      failures++;
      $display("FAIL dir_read: rvalid=%b rdata=%h expected rvalid=1 rdata=ffff0000", reg_rvalid, reg_rdata);
    end
    tick();
    checks++;
    if (reg_rvalid !== 1'b0 || reg_rdata !== 32'hFFFF0000) begin
      failures++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h expected rvalid=0 rdata=ffff0000", reg_rvalid, reg_rdata);
    end
  endtask

  task automatic test_out_rmw();
    drive(1'b1, 2'b10, 32'h04, 32'hF0F0F0F0); tick();
    checks++;
    if (gpio_out !== 32'hF0F0F0F0) begin
      failures++;
      $display("FAIL out_write: out=%h expected f0f0f0f0", gpio_out);
    end
    drive(1'b1, 2'b10, 32'h08, 32'hFF00FF00); tick();
    checks++;
    if (gpio_out !== 32'hF000F000) begin
      failures++;
      $display("FAIL outand: out=%h expected f000f000", gpio_out);
    end
    drive(1'b1, 2'b10, 32'h0C, 32'h0000000F); tick();
    drive(1'b1, 2'b10, 32'h10, 32'h80000000); tick();
    idle();
    checks++;
    if (gpio_out !== 32'h7000F00F) begin
      failures++;
      $display("FAIL out_rmw_chain: out=%h expected 7000f00f", gpio_out);
    end
    drive(1'b0, 2'b10, 32'h04, 32'h0); tick();
    drive(1'b0, 2'b10, 32'h08, 32'h0);
    checks++;
    if (reg_rvalid !== 1'b1 || reg_rdata !== 32'h7000F00F) begin
      failures++;
      $display("FAIL out_read: rvalid=%b rdata=%h expected rvalid=1 rdata=7000f00f", reg_rvalid, reg_rdata);
    end
    tick();
    idle();
    checks++;
    if (reg_rvalid !== 1'b1 || reg_rdata !== 32'h0 || reg_err !== 1'b0) begin
      failures++;
      $display("FAIL outand_read: rvalid=%b rdata=%h err=%b expected rvalid=1 rdata=0 err=0", reg_rvalid, reg_rdata, reg_err);
    end
  endtask

  task automatic test_interrupt();
    drive(1'b1, 2'b10, 32'h14, 32'h00000001); tick();
    idle();
    gpio_in = 32'h1;
    tick();
    tick();
    checks++;
    if (gpio_ilat !== 32'h0) begin
      failures++;
      $display("FAIL ilat_early: ilat=%h expected 00000000 after 2 clocks", gpio_ilat);
    end
    tick();
    checks++;
    if (gpio_ilat !== 32'h1 || gpio_irq !== 1'b1) begin
      failures++;
      $display("FAIL ilat_rise0: ilat=%h irq=%b expected ilat=00000001 irq=1", gpio_ilat, gpio_irq);
    end
    gpio_in = 32'h3;
    tick(); tick(); tick();
    checks++;
    if (gpio_ilat !== 32'h3 || gpio_irq !== 1'b1) begin
      failures++;
      $display("FAIL ilat_rise1: ilat=%h irq=%b expected ilat=00000003 irq=1", gpio_ilat, gpio_irq);
    end
    drive(1'b1, 2'b10, 32'h20, 32'h00000001); tick();
    idle();
    checks++;
    if (gpio_ilat !== 32'h2 || gpio_irq !== 1'b0) begin
      failures++;
      $display("FAIL ilatclr: ilat=%h irq=%b expected ilat=00000002 irq=0", gpio_ilat, gpio_irq);
    end
    drive(1'b0, 2'b10, 32'h1C, 32'h0); tick();
    drive(1'b0, 2'b10, 32'h18, 32'h0);
    checks++;
    if (reg_rvalid !== 1'b1 || reg_rdata !== 32'h2) begin
      failures++;
      $display("FAIL ilat_read: rvalid=%b rdata=%h expected rvalid=1 rdata=00000002", reg_rvalid, reg_rdata);
    end
    tick();
    idle();
    checks++;
    if (reg_rvalid !== 1'b1 || reg_rdata !== 32'h3) begin
      failures++;
      $display("FAIL in_read: rvalid=%b rdata=%h expected rvalid=1 rdata=00000003", reg_rvalid, reg_rdata);
    end
  endtask

  task automatic test_collision();
    gpio_in = 32'h2;
    tick(); tick(); tick();
    gpio_in = 32'h3;
    tick(); tick();
    drive(1'b1, 2'b10, 32'h20, 32'h00000001); tick();
    idle();
    checks++;
    if (gpio_ilat !== 32'h3) begin
      failures++;
      $display("FAIL set_clr_collision: ilat=%h expected 00000003", gpio_ilat);
    end
    tick();
    checks++;
    if (gpio_ilat !== 32'h3 || gpio_irq !== 1'b1) begin
      failures++;
      $display("FAIL collision_hold: ilat=%h irq=%b expected ilat=00000003 irq=1", gpio_ilat, gpio_irq);
    end
  endtask

  task automatic test_rejects();
    drive(1'b1, 2'b01, 32'h04, 32'h00000000); tick();
    idle();
    checks++;
    if (reg_err !== 1'b1 || reg_rvalid !== 1'b0 || gpio_out !== 32'h7000F00F) begin
      failures++;
      $display("FAIL rej_dmode: err=%b rvalid=%b out=%h expected err=1 rvalid=0 out=7000f00f", reg_err, reg_rvalid, gpio_out);
    end
    tick();
    checks++;
    if (reg_err !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: err=%b expected 0", reg_err);
    end
    drive(1'b1, 2'b10, 32'h00000104, 32'h00000000); tick();
    idle();
    checks++;
    if (reg_err !== 1'b1 || gpio_out !== 32'h7000F00F) begin
      failures++;
      $display("FAIL rej_base: err=%b out=%h expected err=1 out=7000f00f", reg_err, gpio_out);
    end
    drive(1'b1, 2'b10, 32'h18, 32'hFFFFFFFF); tick();
    idle();
    checks++;
    if (reg_err !== 1'b1 || reg_rvalid !== 1'b0 || gpio_ilat !== 32'h3) begin
      failures++;
      $display("FAIL rej_write_in: err=%b rvalid=%b ilat=%h expected err=1 rvalid=0 ilat=00000003", reg_err, reg_rvalid, gpio_ilat);
    end
    drive(1'b0, 2'b10, 32'h24, 32'h0); tick();
    idle();
    checks++;
    if (reg_err !== 1'b1 || reg_rvalid !== 1'b1 || reg_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rej_read_unmapped: err=%b rvalid=%b rdata=%h expected err=1 rvalid=1 rdata=0", reg_err, reg_rvalid, reg_rdata);
    end
    tick();
    checks++;
    if (gpio_en !== 32'hFFFF0000 || gpio_out !== 32'h7000F00F || reg_err !== 1'b0 || reg_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rej_no_state_change: en=%h out=%h err=%b rvalid=%b expected en=ffff0000 out=7000f00f err=0 rvalid=0",
               gpio_en, gpio_out, reg_err, reg_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b10, 32'h14, 32'hA5A5A5A5); tick();
    drive(1'b0, 2'b10, 32'h14, 32'h0);
    checks++;
    if (reg_rvalid !== 1'b0 || reg_err !== 1'b0) begin
      failures++;
      $display("FAIL raw_write: rvalid=%b err=%b expected rvalid=0 err=0", reg_rvalid, reg_err);
    end
    tick();
    idle();
    checks++;
    if (reg_rvalid !== 1'b1 || reg_rdata !== 32'hA5A5A5A5 || gpio_irq !== 1'b1) begin
      failures++;
      $display("FAIL raw_read: rvalid=%b rdata=%h irq=%b expected rvalid=1 rdata=a5a5a5a5 irq=1", reg_rvalid, reg_rdata, gpio_irq);
    end
  endtask

  initial begin
    rst        = 1'b1;
    reg_access = 1'b0;
    reg_packet = '0;
    gpio_in    = '0;
    #1;
    checks++;
    if (gpio_out !== 32'h0 || gpio_en !== 32'h0 || gpio_ilat !== 32'h0 || gpio_irq !== 1'b0 ||
        reg_rvalid !== 1'b0 || reg_err !== 1'b0 || reg_rdata !== 32'h0) begin
      failures++;
      $display("FAIL initial_reset: out=%h en=%h ilat=%h irq=%b rvalid=%b err=%b rdata=%h expected all zero",
               gpio_out, gpio_en, gpio_ilat, gpio_irq, reg_rvalid, reg_err, reg_rdata);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_out_rmw();
    test_interrupt();
    test_collision();
    test_rejects();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
